cpu_control_unit: RTL and testbench
===================================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle fetch/decode/control stage of the 8-bit CPU; sits directly upstream of the register file and ALU.
//  Holds the PC, fetches 32-bit instructions via a req/valid handshake and splits them into fields.
//  Drives the register file's read/write addresses and WRITE strobe, plus the ALU op/mux selects.
//  Resolves j/beq and updates the PC once per instruction.
// PARAMETERS
//  PC_WIDTH  32  width of PC and INSTR_ADDR
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  CLK          in   1   clock, all state updates on posedge
//  RESET        in   1   synchronous, active-low reset (RESET==0 at posedge resets)
//  INSTR_ADDR   out  PC_WIDTH  current PC to instruction memory
//  INSTR_REQ    out  1   fetch request, high while in FETCH
//  INSTR_VALID  in   1   instruction memory has INSTRUCTION ready
//  INSTRUCTION  in   32  [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
//  ZERO         in   1   ALU zero flag
//  OUT1ADDRESS  out  3   reg file read port 1 addr (src1[2:0])
//  OUT2ADDRESS  out  3   reg file read port 2 addr (src2[2:0])
//  INADDRESS    out  3   reg file write addr (dest[2:0])
//  WRITE        out  1   reg file write enable, one cycle per writing instruction
//  IMMEDIATE    out  8   instruction[7:0]
//  ALUOP        out  3   000 FWD, 001 ADD, 010 AND, 011 OR
//  NEG_SEL      out  1   1 = ALU operand2 is two's complement (sub, beq)
//  IMM_SEL      out  1   1 = ALU operand2 is IMMEDIATE (loadi)
//  ERROR        out  1   sticky, illegal opcode seen
// BEHAVIOUR
//  All outputs registered. Reset: state=FETCH, PC=RESET_PC, INSTR_REQ=0, WRITE=0, ERROR=0,
//   all addresses/ALUOP/IMMEDIATE/selects = 0. INSTR_REQ rises in the first cycle after RESET returns high.
//  FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is terminal.
//  FETCH: INSTR_REQ=1, INSTR_ADDR=PC. Stays in FETCH while INSTR_VALID=0.
//   When INSTR_VALID=1, latch INSTRUCTION, drop INSTR_REQ, go to DECODE.
//  DECODE: drive OUT1/OUT2ADDRESS, IMMEDIATE, ALUOP, NEG_SEL, IMM_SEL. Opcode > 7 -> ERROR=1, HALT.
//  EXECUTE: selects held steady (covers 2-unit reg read + ALU settle). ZERO sampled at end of cycle (beq).
//  WRITEBACK: WRITE=1 for exactly this cycle for loadi/mov/add/sub/and/or, INADDRESS=dest[2:0].
//   The reg file captures the result at the posedge ending WRITEBACK. PC updated at the same edge.
//  Opcodes: 0 loadi (FWD, IMM_SEL); 1 mov (FWD); 2 add (ADD); 3 sub (ADD, NEG_SEL);
//   4 and (AND); 5 or (OR); 6 j (no write); 7 beq (ADD, NEG_SEL, no write).
//  Next PC: default PC+4. j, or beq with ZERO=1: PC+4+(sext(offset[23:16])<<2).
//   Arithmetic is modulo 2^PC_WIDTH; wrap-around is legal and not flagged.
//  Minimum latency: 4 cycles per instruction, +1 per cycle INSTR_VALID is low.
//  HALT: WRITE=0, INSTR_REQ=0, PC frozen, ERROR=1; left only by reset.
//  Reset mid-instruction (any state, including WRITEBACK): the reset edge wins. No write is issued after it,
//   and the PC goes to RESET_PC. INSTR_VALID arriving in the same cycle as reset is ignored.
//  Upper address bits [7:3] of src/dest are ignored (8 registers).
// STRUCTURE
//  Shared package cpu_pkg: opcode localparams (OP_LOADI..OP_BEQ), ALUOP codes, FSM state encoding,
//   instruction field bit positions.
//  One sub-module: pc_next_logic (PC+4 adder, offset sign-extend/shift, branch mux), combinational.
//  FSM, field latches and output registers live in cpu_control_unit.
// TESTING
//  1 Reset then loadi r3,#0x2A (0x00030000_2A packed as 0x0003002A), INSTR_VALID held 1
//    -> WRITE=1 only in cycle 4, INADDRESS=3, IMM_SEL=1, ALUOP=000; PC 0->4.
//  2 sub r1,r2,r5 (0x03010205) -> OUT1ADDRESS=2, OUT2ADDRESS=5, ALUOP=001, NEG_SEL=1, WRITE=1 with INADDRESS=1.
//  3 At PC=0x10: beq offset 0xFE, ZERO=1 -> PC=0x0C, no WRITE. Same instruction with ZERO=0 -> PC=0x14.
//  4 j offset 0x7F at PC=0xFFFFFFF0 -> PC wraps to 0x000001F0, ERROR stays 0.
//  5 INSTR_VALID low for 3 cycles -> INSTR_REQ stays high, INSTR_ADDR stable, latency = 7 cycles.
//  6 Opcode 0x09 -> ERROR=1, HALT, no WRITE, later INSTR_VALID ignored. Then RESET=0 during WRITEBACK
//    of an add -> WRITE=0 after the edge, PC=RESET_PC, ERROR=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, ALU codes,
// FSM encoding, instruction field positions and the opcode decoder.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       neg_sel;
    logic       imm_sel;
    logic       writes;
    logic       is_jump;
    logic       is_beq;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [7:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LOADI: begin c.aluop = ALU_FWD; c.imm_sel = 1'b1; c.writes = 1'b1; end
      OP_MOV:   begin c.aluop = ALU_FWD; c.writes = 1'b1; end
      OP_ADD:   begin c.aluop = ALU_ADD; c.writes = 1'b1; end
      OP_SUB:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.writes = 1'b1; end
      OP_AND:   begin c.aluop = ALU_AND; c.writes = 1'b1; end
      OP_OR:    begin c.aluop = ALU_OR;  c.writes = 1'b1; end
      OP_J:     begin c.is_jump = 1'b1; end
      OP_BEQ:   begin c.aluop = ALU_ADD; c.neg_sel = 1'b1; c.is_beq = 1'b1; end
      default:  begin c.illegal = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC computation: sequential PC+4, or PC+4 plus a sign-extended word
// offset when a jump/taken branch is selected. Wraps modulo 2^PC_WIDTH.
module pc_next_logic #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          offset,
  input  logic                take,
  output logic [PC_WIDTH-1:0] pc_next
);

  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] disp;

  always_comb begin
    pc_seq  = pc + PC_WIDTH'(4);
    disp    = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
    pc_next = take ? (pc_seq + disp) : pc_seq;
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/control stage: PC, instruction fetch handshake,
// register-file addressing, ALU selects and j/beq resolution.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  output logic [PC_WIDTH-1:0] INSTR_ADDR,
  output logic                INSTR_REQ,
  input  logic                INSTR_VALID,
  input  logic [31:0]         INSTRUCTION,
  input  logic                ZERO,
  output logic [2:0]          OUT1ADDRESS,
  output logic [2:0]          OUT2ADDRESS,
  output logic [2:0]          INADDRESS,
  output logic                WRITE,
  output logic [7:0]          IMMEDIATE,
  output logic [2:0]          ALUOP,
  output logic                NEG_SEL,
  output logic                IMM_SEL,
  output logic                ERROR,
  output state_t              DBG_STATE
);

  state_t              state_q, next_state;
  logic [PC_WIDTH-1:0] pc_q, pc_next;
  logic [7:0]          offset_q;
  logic                writes_q, jump_q, beq_q, illegal_q, zero_q;
  logic                accept;
  ctrl_t               ctrl;
  logic                unused_src1_hi;

  // Fetch handshake: an instruction transfers at a posedge where INSTR_REQ
  // and INSTR_VALID are both high; INSTR_VALID is ignored whenever
  // INSTR_REQ is low (including the first cycle after reset and in HALT).
  assign accept         = (state_q == ST_FETCH) && INSTR_REQ && INSTR_VALID;
  assign ctrl           = decode_op(INSTRUCTION[OPC_LSB +: 8]);
  assign unused_src1_hi = ^INSTRUCTION[SRC1_LSB+3 +: 5];
  assign INSTR_ADDR     = pc_q;
  assign DBG_STATE      = state_q;

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_FETCH:     if (accept) next_state = ST_DECODE;
      ST_DECODE:    next_state = illegal_q ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   next_state = ST_WRITEBACK;
      ST_WRITEBACK: next_state = ST_FETCH;
      ST_HALT:      next_state = ST_HALT;
      default:      next_state = ST_FETCH;
    endcase
  end

  pc_next_logic #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc      (pc_q),
    .offset  (offset_q),
    .take    (jump_q || (beq_q && zero_q)),
    .pc_next (pc_next)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      INSTR_REQ   <= 1'b0;
      WRITE       <= 1'b0;
      ERROR       <= 1'b0;
      OUT1ADDRESS <= '0;
      OUT2ADDRESS <= '0;
      INADDRESS   <= '0;
      IMMEDIATE   <= '0;
      ALUOP       <= ALU_FWD;
      NEG_SEL     <= 1'b0;
      IMM_SEL     <= 1'b0;
      offset_q    <= '0;
      writes_q    <= 1'b0;
      jump_q      <= 1'b0;
      beq_q       <= 1'b0;
      illegal_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q   <= next_state;
      INSTR_REQ <= (next_state == ST_FETCH);
      WRITE     <= (state_q == ST_EXECUTE) && writes_q;
      if (accept) begin
        OUT1ADDRESS <= INSTRUCTION[SRC1_LSB +: 3];
        OUT2ADDRESS <= INSTRUCTION[SRC2_LSB +: 3];
        INADDRESS   <= INSTRUCTION[DST_LSB +: 3];
        IMMEDIATE   <= INSTRUCTION[SRC2_LSB +: 8];
        offset_q    <= INSTRUCTION[DST_LSB +: 8];
        ALUOP       <= ctrl.aluop;
        NEG_SEL     <= ctrl.neg_sel;
        IMM_SEL     <= ctrl.imm_sel;
        writes_q    <= ctrl.writes;
        jump_q      <= ctrl.is_jump;
        beq_q       <= ctrl.is_beq;
        illegal_q   <= ctrl.illegal;
      end
      if (state_q == ST_DECODE && illegal_q) ERROR <= 1'b1;
      // ZERO reflects the ALU result only after the full EXECUTE settle time
      if (state_q == ST_EXECUTE) zero_q <= ZERO;
      if (state_q == ST_WRITEBACK) pc_q <= pc_next;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: driver tasks issue instructions and
// queue expected results; a monitor checks each WRITEBACK and the next PC.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [2:0]  ina;
    logic [2:0]  o1;
    logic [2:0]  o2;
    logic [7:0]  imm;
    logic [2:0]  aluop;
    logic        neg;
    logic        isel;
    logic        chk_alu;
    logic [31:0] npc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTR_ADDR;
  logic        INSTR_REQ;
  logic        INSTR_VALID = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        ZERO = 1'b0;
  logic [2:0]  OUT1ADDRESS, OUT2ADDRESS, INADDRESS, ALUOP;
  logic        WRITE, NEG_SEL, IMM_SEL, ERROR;
  logic [7:0]  IMMEDIATE;
  state_t      DBG_STATE;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          pend_pc = 0;
  logic [31:0] pend_val = '0;

  // clock / reset
  always #5 CLK = ~CLK;

  cpu_control_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTR_ADDR  (INSTR_ADDR),
    .INSTR_REQ   (INSTR_REQ),
    .INSTR_VALID (INSTR_VALID),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .IMMEDIATE   (IMMEDIATE),
    .ALUOP       (ALUOP),
    .NEG_SEL     (NEG_SEL),
    .IMM_SEL     (IMM_SEL),
    .ERROR       (ERROR),
    .DBG_STATE   (DBG_STATE)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic wr, input logic [2:0] ina, input logic [2:0] o1,
                              input logic [2:0] o2, input logic [7:0] imm, input logic [2:0] aluop,
                              input logic neg, input logic isel, input logic ca, input logic [31:0] npc);
    exp_t e;
    e = '{wr, ina, o1, o2, imm, aluop, neg, isel, ca, npc};
    return e;
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    exp_t e;
    if (pend_pc) begin
      chk("next_pc", INSTR_ADDR, pend_val);
      pend_pc = 0;
    end
    if (DBG_STATE == ST_WRITEBACK) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got writeback want none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_write", WRITE, e.wr);
        if (e.wr) chk("wb_inaddr", INADDRESS, e.ina);
        if (e.chk_alu) begin
          chk("wb_out1", OUT1ADDRESS, e.o1);
          chk("wb_out2", OUT2ADDRESS, e.o2);
          chk("wb_imm", IMMEDIATE, e.imm);
          chk("wb_aluop", ALUOP, e.aluop);
          chk("wb_neg", NEG_SEL, e.neg);
          chk("wb_immsel", IMM_SEL, e.isel);
        end
        pend_pc  = 1;
        pend_val = e.npc;
      end
    end else begin
      chk("write_idle", WRITE, 1'b0);
    end
  end

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (INSTR_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = (INSTR_REQ === 1'b1);
    if (!ok) chk("req_timeout", {31'b0, INSTR_REQ}, 32'h1);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int stall, input logic z, input exp_t e);
    bit          ok;
    int          lat, n;
    logic [31:0] a0;
    wait_req(ok);
    if (ok) begin
      a0 = INSTR_ADDR;
      exp_q.push_back(e);
      ZERO = z;
      INSTRUCTION = ins;
      lat = 0;
      repeat (stall) begin
        INSTR_VALID = 1'b0;
        @(negedge CLK);
        lat++;
        chk("stall_req", INSTR_REQ, 1'b1);
        chk("stall_addr", INSTR_ADDR, a0);
      end
      INSTR_VALID = 1'b1;
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      lat++;
      n = 0;
      while (INSTR_REQ !== 1'b1 && n < 20) begin
        @(negedge CLK);
        lat++;
        n++;
      end
      chk("latency", lat, 4 + stall);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req", INSTR_REQ, 1'b0);
    chk("rst_write", WRITE, 1'b0);
    chk("rst_error", ERROR, 1'b0);
    chk("rst_pc", INSTR_ADDR, 32'h0);
    chk("rst_aluop", ALUOP, 3'b000);
    chk("rst_neg", NEG_SEL, 1'b0);
    chk("rst_immsel", IMM_SEL, 1'b0);
    chk("rst_imm", IMMEDIATE, 8'h00);
    chk("rst_out1", OUT1ADDRESS, 3'd0);
    chk("rst_out2", OUT2ADDRESS, 3'd0);
    chk("rst_inaddr", INADDRESS, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    RESET = 1'b0;
    INSTR_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    INSTR_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    chk("req_after_reset", INSTR_REQ, 1'b1);

    //        instr          stall zero  wr ina o1 o2 imm    alu   neg isel chk npc
    run_instr(32'h0003002A, 0, 1'b0, mk(1, 3, 0, 2, 8'h2A, 3'b000, 0, 1, 1, 32'h4));
    run_instr(32'h03010205, 0, 1'b0, mk(1, 1, 2, 5, 8'h05, 3'b001, 1, 0, 1, 32'h8));
    run_instr(32'h04040607, 0, 1'b0, mk(1, 4, 6, 7, 8'h07, 3'b010, 0, 0, 1, 32'hC));
    run_instr(32'h05070001, 0, 1'b0, mk(1, 7, 0, 1, 8'h01, 3'b011, 0, 0, 1, 32'h10));
    run_instr(32'h07FE0102, 0, 1'b1, mk(0, 0, 1, 2, 8'h02, 3'b001, 1, 0, 1, 32'hC));
    run_instr(32'h01020300, 0, 1'b0, mk(1, 2, 3, 0, 8'h00, 3'b000, 0, 0, 1, 32'h10));
    run_instr(32'h07FE0102, 0, 1'b0, mk(0, 0, 1, 2, 8'h02, 3'b001, 1, 0, 1, 32'h14));
    run_instr(32'h01051A0B, 3, 1'b0, mk(1, 5, 2, 3, 8'h0B, 3'b000, 0, 0, 1, 32'h18));
    run_instr(32'h06F50000, 0, 1'b0, mk(0, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0, 32'hFFFFFFF0));
    run_instr(32'h067F0000, 0, 1'b0, mk(0, 0, 0, 0, 8'h00, 3'b000, 0, 0, 0, 32'h000001F0));
    chk("error_after_wrap", ERROR, 1'b0);

    // illegal opcode: halt, sticky error, further fetch data ignored
    wait_req(ok);
    INSTRUCTION = 32'h09000000;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    chk("halt_error", ERROR, 1'b1);
    chk("halt_state", DBG_STATE, ST_HALT);
    INSTRUCTION = 32'h0003002A;
    INSTR_VALID = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("halt_req", INSTR_REQ, 1'b0);
      chk("halt_pc", INSTR_ADDR, 32'h000001F0);
      chk("halt_error_sticky", ERROR, 1'b1);
    end
    INSTR_VALID = 1'b0;

    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs();
    RESET = 1'b1;
    @(negedge CLK);
    chk("req_after_reset2", INSTR_REQ, 1'b1);

    // reset lands on the edge ending WRITEBACK of an add
    wait_req(ok);
    exp_q.push_back(mk(1, 2, 3, 4, 8'h04, 3'b001, 0, 0, 1, 32'h0));
    INSTRUCTION = 32'h02020304;
    INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("wb_before_reset", DBG_STATE, ST_WRITEBACK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midwb_write", WRITE, 1'b0);
    chk("midwb_pc", INSTR_ADDR, 32'h0);
    chk("midwb_error", ERROR, 1'b0);
    chk("midwb_req", INSTR_REQ, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("req_after_reset3", INSTR_REQ, 1'b1);

    run_instr(32'h0006FF81, 0, 1'b0, mk(1, 6, 7, 1, 8'h81, 3'b000, 0, 1, 1, 32'h4));

    repeat (3) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
